// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control sequencer: ALUOp encodings, funct
// field values, ALU control codes and the sequencer state enum.
package alu_ctrl_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_LOGIC = 2'b11;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_XOR  = 4'b0011;
    localparam logic [3:0] C_SUBU = 4'b0101;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SLT  = 4'b0111;
    localparam logic [3:0] C_SLL  = 4'b1000;
    localparam logic [3:0] C_SRL  = 4'b1001;
    localparam logic [3:0] C_SRA  = 4'b1010;
    localparam logic [3:0] C_NOR  = 4'b1100;
    localparam logic [3:0] C_MUL  = 4'b1101;
    localparam logic [3:0] C_DIV  = 4'b1110;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_MD_RUN = 1'b1
    } state_t;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational ALUOp/funct decoder producing the 4-bit ALU control code and
// mul/div classification. Mult/div decode exists only when
// ALU_CTRL_SEQ_MULDIV_EN is defined; otherwise those functs fall to 0000.
module alu_funct_decode
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W    = 2,
    parameter int FUNCT_W = 6
) (
    input  logic [OP_W-1:0]    alu_op,
    input  logic [FUNCT_W-1:0] funct,
    output logic [3:0]         code,
    output logic               is_md,
    output logic               is_div
);

    // Decode table; unknown combinations give the AND code.
    always_comb begin
        code   = C_AND;
        is_md  = 1'b0;
        is_div = 1'b0;
        case (alu_op)
            OP_W'(ALUOP_ADD):   code = C_ADD;
            OP_W'(ALUOP_SUB):   code = C_SUB;
            OP_W'(ALUOP_LOGIC): code = C_AND;
            OP_W'(ALUOP_FUNCT): begin
                case (funct)
                    FUNCT_W'(F_ADD), FUNCT_W'(F_ADDU): code = C_ADD;
                    FUNCT_W'(F_SUB):                   code = C_SUB;
                    FUNCT_W'(F_SUBU):                  code = C_SUBU;
                    FUNCT_W'(F_AND):                   code = C_AND;
                    FUNCT_W'(F_OR):                    code = C_OR;
                    FUNCT_W'(F_XOR):                   code = C_XOR;
                    FUNCT_W'(F_NOR):                   code = C_NOR;
                    FUNCT_W'(F_SLT), FUNCT_W'(F_SLTU): code = C_SLT;
                    FUNCT_W'(F_SLL):                   code = C_SLL;
                    FUNCT_W'(F_SRL):                   code = C_SRL;
                    FUNCT_W'(F_SRA):                   code = C_SRA;
`ifdef ALU_CTRL_SEQ_MULDIV_EN
                    FUNCT_W'(F_MULT), FUNCT_W'(F_MULTU): begin
                        code  = C_MUL;
                        is_md = 1'b1;
                    end
                    FUNCT_W'(F_DIV), FUNCT_W'(F_DIVU): begin
                        code   = C_DIV;
                        is_md  = 1'b1;
                        is_div = 1'b1;
                    end
`endif
                    default: code = C_AND;
                endcase
            end
            default: code = C_AND;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with valid/ready handshake and a multi-cycle
// mul/div sequencer that stalls issue while the iterative unit runs.
// Mul/div support is enabled by defining ALU_CTRL_SEQ_MULDIV_EN; without it
// the FSM never leaves IDLE and the md_* outputs stay 0.
//
// state     | meaning
// ST_IDLE   | accepting requests; ctrl_alu/out_valid hold until consumed
// ST_MD_RUN | mul/div iterating, cnt counts down to 0, issue stalled
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W      = 2,
    parameter int FUNCT_W   = 6,
    parameter int CTRL_W    = 4,
    parameter int MD_CYCLES = 32,
    parameter int CNT_W     = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    alu_op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  ctrl_alu,
    output logic               md_start,
    output logic               md_div,
    output logic               md_busy,
    output logic               stall
);

`ifdef ALU_CTRL_SEQ_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic                md_start_q, md_start_d;
    logic                md_div_q, md_div_d;
    logic                md_busy_q, md_busy_d;

    logic [3:0]          dec_code;
    logic                dec_is_md;
    logic                dec_is_div;
    logic                hold;
    logic                accept;

    alu_funct_decode #(
        .OP_W    (OP_W),
        .FUNCT_W (FUNCT_W)
    ) u_decode (
        .alu_op (alu_op),
        .funct  (funct),
        .code   (dec_code),
        .is_md  (dec_is_md),
        .is_div (dec_is_div)
    );

    assign hold     = out_valid_q && !out_ready;
    assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    assign out_valid = out_valid_q;
    assign ctrl_alu  = ctrl_q;
    assign md_start  = md_start_q;
    assign md_div    = md_div_q;
    assign md_busy   = md_busy_q;
    assign stall     = (state_q == ST_MD_RUN) || hold;

    // Next-state and output-register logic; flush overrides everything,
    // including a request accepted in the same cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        md_start_d  = 1'b0;
        md_div_d    = md_div_q;
        md_busy_d   = md_busy_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ctrl_d = CTRL_W'(dec_code);
                    if (dec_is_md && MD_EN) begin
                        state_d    = ST_MD_RUN;
                        cnt_d      = CNT_W'(MD_CYCLES - 1);
                        md_start_d = 1'b1;
                        md_div_d   = dec_is_div;
                        md_busy_d  = 1'b1;
                    end else begin
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_MD_RUN: begin
                if (cnt_q == '0) begin
                    out_valid_d = 1'b1;
                    md_busy_d   = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            ctrl_d      = ctrl_q;
            md_start_d  = 1'b0;
            md_div_d    = md_div_q;
            md_busy_d   = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            md_start_q  <= 1'b0;
            md_div_q    <= 1'b0;
            md_busy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            md_start_q  <= md_start_d;
            md_div_q    <= md_div_d;
            md_busy_q   <= md_busy_d;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: decode table, directed handshake and
// mul/div sequences, then randomized traffic against a transaction model.
// Mul/div expectations follow ALU_CTRL_SEQ_MULDIV_EN.
module tb_alu_ctrl_seq;

    localparam int MDC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] alu_op;
    logic [5:0] funct;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] ctrl_alu;
    logic       md_start;
    logic       md_div;
    logic       md_busy;
    logic       stall;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_ctrl_seq #(
        .OP_W      (2),
        .FUNCT_W   (6),
        .CTRL_W    (4),
        .MD_CYCLES (MDC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct     (funct),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ctrl_alu  (ctrl_alu),
        .md_start  (md_start),
        .md_div    (md_div),
        .md_busy   (md_busy),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    // Reference decode: lookup tables built from the opcode listing.
    logic [3:0] fmap [64];
    int         md_kind [64];   // 0 none, 1 multiply, 2 divide

    // Transaction-level model of what the outputs should be.
    bit         m_ov;
    logic [3:0] m_oc;
    int         m_busy;         // remaining busy cycles, 0 = idle
    bit         m_start;
    bit         m_div;
    logic [3:0] m_pend;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic ref_decode(input logic [1:0] op, input logic [5:0] f,
                              output logic [3:0] code, output bit is_md, output bit is_div);
        is_md  = 1'b0;
        is_div = 1'b0;
        case (op)
            2'd0: code = 4'd2;
            2'd1: code = 4'd6;
            2'd3: code = 4'd0;
            default: begin
                code   = fmap[f];
                is_md  = (md_kind[f] != 0);
                is_div = (md_kind[f] == 2);
            end
        endcase
    endtask

    task automatic model_reset();
        m_ov    = 1'b0;
        m_oc    = 4'd0;
        m_busy  = 0;
        m_start = 1'b0;
        m_div   = 1'b0;
        m_pend  = 4'd0;
    endtask

    task automatic model_check();
        bit exp_ready;
        bit exp_stall;
        exp_ready = (m_busy == 0) && (!m_ov || out_ready);
        exp_stall = (m_busy > 0) || (m_ov && !out_ready);
        chk("model_out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) chk("model_ctrl_alu", 32'(ctrl_alu), 32'(m_oc));
        chk("model_in_ready", 32'(in_ready), 32'(exp_ready));
        chk("model_stall", 32'(stall), 32'(exp_stall));
        chk("model_md_start", 32'(md_start), 32'(m_start));
        chk("model_md_busy", 32'(md_busy), 32'(m_busy > 0));
        if (m_busy > 0) chk("model_md_div", 32'(md_div), 32'(m_div));
    endtask

    task automatic model_update();
        bit         acc;
        logic [3:0] code;
        bit         is_md;
        bit         is_div;
        bit         nstart;
        nstart = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            acc = in_valid && (m_busy == 0) && (!m_ov || out_ready);
            if (flush) begin
                m_ov   = 1'b0;
                m_busy = 0;
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_ov = 1'b1;
                    m_oc = m_pend;
                end
            end else begin
                if (m_ov && out_ready) m_ov = 1'b0;
                if (acc) begin
                    ref_decode(alu_op, funct, code, is_md, is_div);
                    if (is_md) begin
                        m_busy = MDC;
                        nstart = 1'b1;
                        m_div  = is_div;
                        m_pend = code;
                    end else begin
                        m_ov = 1'b1;
                        m_oc = code;
                    end
                end
            end
            m_start = nstart;
        end
    endtask

    // Check current outputs, advance one clock, update the model.
    task automatic tick();
        #1;
        model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [1:0] op, input logic [5:0] f, input bit ordy, input bit fl);
        in_valid  = v;
        alu_op    = op;
        funct     = f;
        out_ready = ordy;
        flush     = fl;
    endtask

    typedef struct {
        logic [1:0] op;
        logic [5:0] f;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mkv(input logic [1:0] op, input logic [5:0] f, input logic [3:0] e);
        vec_t v;
        v.op  = op;
        v.f   = f;
        v.exp = e;
        return v;
    endfunction

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] fpick [20];
        int         cnt;
        bit         saw_ov;

        for (int i = 0; i < 64; i++) begin
            fmap[i]    = 4'd0;
            md_kind[i] = 0;
        end
        fmap[6'b100000] = 4'b0010; fmap[6'b100001] = 4'b0010;
        fmap[6'b100010] = 4'b0110; fmap[6'b100011] = 4'b0101;
        fmap[6'b100100] = 4'b0000; fmap[6'b100101] = 4'b0001;
        fmap[6'b100110] = 4'b0011; fmap[6'b100111] = 4'b1100;
        fmap[6'b101010] = 4'b0111; fmap[6'b101011] = 4'b0111;
        fmap[6'b000000] = 4'b1000; fmap[6'b000010] = 4'b1001;
        fmap[6'b000011] = 4'b1010;
`ifdef ALU_CTRL_SEQ_MULDIV_EN
        fmap[6'b011000] = 4'b1101; fmap[6'b011001] = 4'b1101;
        fmap[6'b011010] = 4'b1110; fmap[6'b011011] = 4'b1110;
        md_kind[6'b011000] = 1; md_kind[6'b011001] = 1;
        md_kind[6'b011010] = 2; md_kind[6'b011011] = 2;
`endif

        vecs.push_back(mkv(2'b10, 6'b100010, 4'b0110));
        vecs.push_back(mkv(2'b00, 6'b111111, 4'b0010));
        vecs.push_back(mkv(2'b01, 6'b000000, 4'b0110));
        vecs.push_back(mkv(2'b11, 6'b100101, 4'b0000));
        vecs.push_back(mkv(2'b10, 6'b100000, 4'b0010));
        vecs.push_back(mkv(2'b10, 6'b100001, 4'b0010));
        vecs.push_back(mkv(2'b10, 6'b100011, 4'b0101));
        vecs.push_back(mkv(2'b10, 6'b100100, 4'b0000));
        vecs.push_back(mkv(2'b10, 6'b100101, 4'b0001));
        vecs.push_back(mkv(2'b10, 6'b100110, 4'b0011));
        vecs.push_back(mkv(2'b10, 6'b100111, 4'b1100));
        vecs.push_back(mkv(2'b10, 6'b101010, 4'b0111));
        vecs.push_back(mkv(2'b10, 6'b101011, 4'b0111));
        vecs.push_back(mkv(2'b10, 6'b000000, 4'b1000));
        vecs.push_back(mkv(2'b10, 6'b000010, 4'b1001));
        vecs.push_back(mkv(2'b10, 6'b000011, 4'b1010));
        vecs.push_back(mkv(2'b10, 6'b111111, 4'b0000));
        vecs.push_back(mkv(2'b10, 6'b000001, 4'b0000));
`ifndef ALU_CTRL_SEQ_MULDIV_EN
        vecs.push_back(mkv(2'b10, 6'b011001, 4'b0000));
        vecs.push_back(mkv(2'b10, 6'b011011, 4'b0000));
`endif

        // Reset
        rst = 1'b1;
        drive(1'b0, 2'b00, 6'b000000, 1'b1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_ctrl_alu", 32'(ctrl_alu), 32'd0);
        chk("rst_md_start", 32'(md_start), 32'd0);
        chk("rst_md_busy", 32'(md_busy), 32'd0);
        chk("rst_md_div", 32'(md_div), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Decode table, issued back-to-back with out_ready high
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].op, vecs[i].f, 1'b1, 1'b0);
            #1;
            chk("tbl_in_ready", 32'(in_ready), 32'd1);
            chk("tbl_stall", 32'(stall), 32'd0);
            tick();
            chk("tbl_out_valid", 32'(out_valid), 32'd1);
            chk($sformatf("tbl_ctrl_%0d", i), 32'(ctrl_alu), 32'(vecs[i].exp));
        end
        drive(1'b0, 2'b00, 6'b000000, 1'b1, 1'b0);
        tick();
        chk("drain_out_valid", 32'(out_valid), 32'd0);

        // Backpressure: slt result held for two cycles
        drive(1'b1, 2'b10, 6'b101010, 1'b1, 1'b0);
        tick();
        drive(1'b1, 2'b00, 6'b000000, 1'b0, 1'b0);
        #1;
        chk("bp_stall", 32'(stall), 32'd1);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("bp_hold1_valid", 32'(out_valid), 32'd1);
        chk("bp_hold1_ctrl", 32'(ctrl_alu), 32'h7);
        tick();
        chk("bp_hold2_ctrl", 32'(ctrl_alu), 32'h7);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        chk("bp_next_ctrl", 32'(ctrl_alu), 32'h2);
        drive(1'b0, 2'b00, 6'b000000, 1'b1, 1'b0);
        tick();

`ifdef ALU_CTRL_SEQ_MULDIV_EN
        // Divide: start pulse, busy for MDC cycles, then result
        drive(1'b1, 2'b10, 6'b011010, 1'b1, 1'b0);
        tick();
        drive(1'b0, 2'b00, 6'b000000, 1'b1, 1'b0);
        chk("div_md_start", 32'(md_start), 32'd1);
        chk("div_md_div", 32'(md_div), 32'd1);
        chk("div_stall", 32'(stall), 32'd1);
        chk("div_in_ready", 32'(in_ready), 32'd0);
        cnt = 0;
        while (md_busy && cnt < 3 * MDC) begin
            cnt++;
            chk("div_start_pulse", 32'(md_start), 32'(cnt == 1));
            chk("div_no_early_valid", 32'(out_valid), 32'd0);
            tick();
        end
        chk("div_busy_cycles", 32'(cnt), 32'(MDC));
        chk("div_out_valid", 32'(out_valid), 32'd1);
        chk("div_ctrl", 32'(ctrl_alu), 32'hE);
        tick();

        // Flush during the second MD_RUN cycle
        drive(1'b1, 2'b10, 6'b011000, 1'b1, 1'b0);
        tick();
        drive(1'b0, 2'b00, 6'b000000, 1'b1, 1'b0);
        chk("mul_md_div", 32'(md_div), 32'd0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_md_busy", 32'(md_busy), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_stall", 32'(stall), 32'd0);
        saw_ov = 1'b0;
        for (int i = 0; i < MDC + 2; i++) begin
            if (out_valid) saw_ov = 1'b1;
            tick();
        end
        chk("flush_no_result", 32'(saw_ov), 32'd0);
`else
        // Mult without the sequencer: plain single-cycle decode to 0000
        drive(1'b1, 2'b10, 6'b011000, 1'b1, 1'b0);
        tick();
        drive(1'b0, 2'b00, 6'b000000, 1'b1, 1'b0);
        chk("nomd_out_valid", 32'(out_valid), 32'd1);
        chk("nomd_ctrl", 32'(ctrl_alu), 32'h0);
        chk("nomd_md_start", 32'(md_start), 32'd0);
        chk("nomd_md_busy", 32'(md_busy), 32'd0);
        tick();
`endif

        // Flush beats a same-cycle accept
        drive(1'b1, 2'b10, 6'b100101, 1'b1, 1'b1);
        tick();
        drive(1'b0, 2'b00, 6'b000000, 1'b1, 1'b0);
        chk("flush_drop_valid", 32'(out_valid), 32'd0);
        tick();

        // Randomized traffic against the model
        fpick = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                  6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011,
                  6'b000000, 6'b000010, 6'b000011, 6'b011000, 6'b011001,
                  6'b011010, 6'b011011, 6'b111111, 6'b010101, 6'b000001};
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 7,
                  2'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0) ? 6'($urandom) : fpick[$urandom_range(0, 19)],
                  $urandom_range(0, 9) < 7,
                  $urandom_range(0, 29) == 0);
            tick();
        end

        // Mid-run reset
        drive(1'b1, 2'b10, 6'b011011, 1'b1, 1'b0);
        tick();
        drive(1'b0, 2'b00, 6'b000000, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_md_busy", 32'(md_busy), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < MDC + 2; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
